// File: rtl/fd_queue.sv
// Fetch->decode instruction queue: DEPTH-entry circular buffer of {instr, PC, PC+4}
// with ISA-correct NOP bubbles when empty. Optional same-cycle bypass under FDQ_BYPASS_EN.
module fd_queue #(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arm,
  input  logic            ValidF,
  input  logic [XLEN-1:0] RDF,
  input  logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] PCPlus4F,
  output logic            ReadyF,
  output logic            ValidD,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic [XLEN-1:0] PCPlus8D,
  input  logic            StallD,
  input  logic            FlushD,
  output logic [CNTW-1:0] CountD
);

  localparam int unsigned PTRW = $clog2(DEPTH);

  localparam logic [XLEN-1:0] ARM_NOP   = XLEN'(32'hE1A0_0000);
  localparam logic [XLEN-1:0] RISCV_NOP = XLEN'(32'h0000_0013);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } fd_pkt_t;

  fd_pkt_t         mem_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q,  count_d;

  fd_pkt_t in_pkt_c;
  fd_pkt_t head_pkt_c;
  logic    stored_valid_c;
  logic    bypass_c;
  logic    push_c;
  logic    pop_c;
  logic    mem_wr_c;
  logic    mem_rd_c;

  assign in_pkt_c       = '{instr: RDF, pc: PCF, pc_plus4: PCPlus4F};
  assign stored_valid_c = (count_q != '0);

  // Refusal while full is deliberate: no look-ahead at a same-cycle pop.
  assign ReadyF = !rst && (count_q < CNTW'(DEPTH));

`ifdef FDQ_BYPASS_EN
  assign bypass_c = !rst && !stored_valid_c && ValidF;
`else
  assign bypass_c = 1'b0;
`endif

  assign head_pkt_c = stored_valid_c ? mem_q[rd_ptr_q] : in_pkt_c;
  assign ValidD     = stored_valid_c || bypass_c;

  assign push_c = ValidF && ReadyF;
  assign pop_c  = ValidD && !StallD;

  // A bypassed packet consumed this cycle never touches storage.
  assign mem_wr_c = push_c && !FlushD && !(bypass_c && pop_c);
  assign mem_rd_c = pop_c && !FlushD && stored_valid_c;

  // Head outputs: real packet or bubble.
  always_comb begin
    InstrD   = arm ? ARM_NOP : RISCV_NOP;
    PCD      = '0;
    PCPlus4D = '0;
    PCPlus8D = '0;
    if (ValidD) begin
      InstrD   = head_pkt_c.instr;
      PCD      = head_pkt_c.pc;
      PCPlus4D = head_pkt_c.pc_plus4;
      if (arm) begin
        PCPlus8D = head_pkt_c.pc_plus4 + XLEN'(4);
      end
    end
  end

  assign CountD = count_q;

  // Pointer and occupancy next-state; flush clears everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (FlushD) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (mem_wr_c) begin
        wr_ptr_d = wr_ptr_q + PTRW'(1);
      end
      if (mem_rd_c) begin
        rd_ptr_d = rd_ptr_q + PTRW'(1);
      end
      case ({mem_wr_c, mem_rd_c})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count qualifies every read.
  always_ff @(posedge clk) begin
    if (mem_wr_c) begin
      mem_q[wr_ptr_q] <= in_pkt_c;
    end
  end

endmodule

// File: tb/tb_fd_queue.sv
// Scoreboard bench for fd_queue (default build, DEPTH=2): directed stimulus pushes
// expected head packets; a negedge monitor checks every consumed head in order.
module tb_fd_queue;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CNTW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            arm;
  logic            ValidF;
  logic [XLEN-1:0] RDF, PCF, PCPlus4F;
  logic            ReadyF, ValidD;
  logic [XLEN-1:0] InstrD, PCD, PCPlus4D, PCPlus8D;
  logic            StallD, FlushD;
  logic [CNTW-1:0] CountD;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] pc8;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  fd_queue #(.XLEN(XLEN), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .arm(arm),
    .ValidF(ValidF), .RDF(RDF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .ReadyF(ReadyF), .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .PCPlus8D(PCPlus8D),
    .StallD(StallD), .FlushD(FlushD), .CountD(CountD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hC000_0000 | pc;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic stall, input logic flush);
    ValidF   = v;
    PCF      = pc;
    RDF      = instr_of(pc);
    PCPlus4F = pc + 32'd4;
    StallD   = stall;
    FlushD   = flush;
  endtask

  task automatic expect_pkt(input logic [31:0] pc, input logic arm_mode);
    exp_t e;
    e.instr = instr_of(pc);
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    e.pc8   = arm_mode ? pc + 32'd8 : 32'd0;
    exp_q.push_back(e);
  endtask

  // Monitor: every head consumed by decode must match the next expected packet.
  always @(negedge clk) begin
    if (!rst && ValidD && !StallD && !FlushD) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_head: got PC %08h expected none", PCD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("head_instr", InstrD, e.instr);
        check("head_pc", PCD, e.pc);
        check("head_pc4", PCPlus4D, e.pc4);
        check("head_pc8", PCPlus8D, e.pc8);
      end
    end
  end

  initial begin
    rst = 1'b1; arm = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick(); tick();

    // Reset state
    check("rst_count", 32'(CountD), 32'd0);
    check("rst_validd", 32'(ValidD), 32'd0);
    check("rst_readyf", 32'(ReadyF), 32'd0);
    check("rst_bubble_arm", InstrD, 32'hE1A0_0000);
    check("rst_pcd", PCD, 32'd0);
    arm = 1'b0;
    #1;
    check("rst_bubble_rv", InstrD, 32'h0000_0013);
    rst = 1'b0;
    #1;
    check("post_rst_readyf", 32'(ReadyF), 32'd1);

    // Fill/drain with decode stalled
    drive(1'b1, 32'h100, 1'b1, 1'b0); expect_pkt(32'h100, 1'b0);
    tick();
    drive(1'b1, 32'h104, 1'b1, 1'b0); expect_pkt(32'h104, 1'b0);
    check("fill1_count", 32'(CountD), 32'd1);
    check("fill1_validd", 32'(ValidD), 32'd1);
    tick();
    drive(1'b1, 32'h108, 1'b1, 1'b0);
    check("fill2_count", 32'(CountD), 32'd2);
    check("fill2_readyf", 32'(ReadyF), 32'd0);
    tick();
    check("full_ignored_count", 32'(CountD), 32'd2);
    check("full_head_pc", PCD, 32'h100);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("drain1_pc", PCD, 32'h104);
    tick();
    check("drain_validd", 32'(ValidD), 32'd0);
    check("drain_bubble", InstrD, 32'h0000_0013);
    check("drain_pcd", PCD, 32'd0);
    check("drain_count", 32'(CountD), 32'd0);

    // Wrap: back-to-back push+pop, head lags fetch by one cycle
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
      expect_pkt(32'h300 + 32'(4 * i), 1'b0);
      if (i > 0) begin
        check("wrap_pcd_lag", PCD, 32'h300 + 32'(4 * (i - 1)));
        check("wrap_count", 32'(CountD), 32'd1);
      end
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("wrap_last_pc", PCD, 32'h310);
    tick();
    check("wrap_empty", 32'(CountD), 32'd0);

    // Flush at full with stall and an incoming packet
    drive(1'b1, 32'h180, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h184, 1'b1, 1'b0); tick();
    check("flush_pre_count", 32'(CountD), 32'd2);
    drive(1'b1, 32'h200, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("flush_count", 32'(CountD), 32'd0);
    check("flush_validd", 32'(ValidD), 32'd0);
    tick();
    // Flush at CountD=1 where the push would otherwise be accepted
    drive(1'b1, 32'h1C0, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h204, 1'b0, 1'b1);
    check("flush2_readyf", 32'(ReadyF), 32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("flush2_count", 32'(CountD), 32'd0);
    tick(); tick();

    // ARM PC+8 versus RISC-V
    arm = 1'b1;
    drive(1'b1, 32'h1000, 1'b0, 1'b0); expect_pkt(32'h1000, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("arm_pc8", PCPlus8D, 32'h1008);
    tick();
    check("arm_bubble", InstrD, 32'hE1A0_0000);
    arm = 1'b0;
    drive(1'b1, 32'h1000, 1'b0, 1'b0); expect_pkt(32'h1000, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("rv_pc8", PCPlus8D, 32'd0);
    tick();

    // Full queue: pop happens, push refused, then accepted next cycle
    drive(1'b1, 32'h400, 1'b1, 1'b0); expect_pkt(32'h400, 1'b0); tick();
    drive(1'b1, 32'h404, 1'b1, 1'b0); expect_pkt(32'h404, 1'b0); tick();
    drive(1'b1, 32'h408, 1'b0, 1'b0); expect_pkt(32'h408, 1'b0);
    check("fpp_readyf", 32'(ReadyF), 32'd0);
    tick();
    check("fpp_count", 32'(CountD), 32'd1);
    check("fpp_readyf_next", 32'(ReadyF), 32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("fpp_count2", 32'(CountD), 32'd1);
    tick();
    check("fpp_empty", 32'(CountD), 32'd0);

    // Asynchronous reset mid-stream at CountD=2
    arm = 1'b1;
    drive(1'b1, 32'h500, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h504, 1'b1, 1'b0); tick();
    check("mid_pre_count", 32'(CountD), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_count", 32'(CountD), 32'd0);
    check("mid_rst_validd", 32'(ValidD), 32'd0);
    check("mid_rst_readyf", 32'(ReadyF), 32'd0);
    check("mid_rst_bubble", InstrD, 32'hE1A0_0000);
    check("mid_rst_pc8", PCPlus8D, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick(); tick();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
